hawk_axi_rd_arb: RTL and testbench
==================================

Name: hawk_axi_rd_arb

Overview:
- Shares the single HAWK AXI4 read master between NUM_REQ read managers (page-writer, compression manager, decompression manager).
- Round-robin arbitration with session locking: a manager can hold ownership across a multi-transaction sequence, such as an iWay pointer walk followed by single-beat reads of a compressed page.
- Tracks outstanding read transactions and routes R-channel beats back to the owning requester.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 wins the first arbitration after reset.
- ADDR_W, 64, AXI address width.
- DATA_W, 512, AXI data width.
- OUTS_MAX, 4, maximum outstanding AR transactions; counter width is clog2(OUTS_MAX+1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  NUM_REQ  per-requester AR request valid
- req_lock_i  in  NUM_REQ  hold ownership after the current request
- req_addr_i  in  NUM_REQ*ADDR_W  per-requester araddr
- req_len_i  in  NUM_REQ*8  per-requester arlen
- req_ready_o  out  NUM_REQ  AR accepted for this requester (arready gated)
- grant_o  out  NUM_REQ  one-hot current owner, registered
- rsp_valid_o  out  NUM_REQ  R beat valid, routed to owner
- rsp_data_o  out  DATA_W  shared rdata
- rsp_resp_o  out  2  shared rresp
- rsp_last_o  out  1  shared rlast
- rsp_ready_i  in  NUM_REQ  per-requester rready
- m_arvalid_o  out  1  AXI arvalid
- m_araddr_o  out  ADDR_W  AXI araddr
- m_arlen_o  out  8  AXI arlen
- m_arready_i  in  1  AXI arready
- m_rvalid_i  in  1  AXI rvalid
- m_rdata_i  in  DATA_W  AXI rdata
- m_rresp_i  in  2  AXI rresp
- m_rlast_i  in  1  AXI rlast
- m_rready_o  out  1  AXI rready
- outstanding_o  out  clog2(OUTS_MAX+1)  current outstanding count
- arb_err_o  out  1  sticky protocol error

Behaviour:
- Reset values: state IDLE, grant_o=0, rr_ptr=0, outstanding_o=0, arb_err_o=0. Registered outputs reset to 0; combinational outputs evaluate to 0/idle (m_arvalid_o=0, req_ready_o=0, rsp_valid_o=0, m_rready_o=1).
- Reset asserted mid-operation aborts all tracking. In-flight R beats arriving after reset are handled by the error rule below.
- State IDLE:
  - If any req_valid_i bit is set, pick the first set bit searching from rr_ptr upward with wrap.
  - Register the one-hot grant, set rr_ptr = winner+1 (mod NUM_REQ), and go to OWNED.
  - Arbitration latency is 1 cycle; the first AR can issue in the cycle after the request.
- State OWNED (owner o):
  - m_arvalid_o = req_valid_i[o] && outstanding < OUTS_MAX.
  - m_araddr_o and m_arlen_o mux from owner o; all are zero when no owner.
  - req_ready_o[o] = m_arvalid_o && m_arready_i; other req_ready_o bits are 0.
  - When !req_valid_i[o] && !req_lock_i[o] in the same cycle: go to DRAIN if outstanding != 0 (counting this cycle's update), else to IDLE with grant cleared.
- State DRAIN:
  - No AR issued.
  - grant_o is held so responses keep routing to the old owner.
  - When outstanding reaches 0, go to IDLE and clear grant.
- Outstanding counter:
  - +1 on an AR handshake.
  - -1 on an R handshake with rlast.
  - Both in the same cycle: no change.
  - Never wraps: AR is gated at OUTS_MAX.
- R routing:
  - rsp_valid_o[o] = m_rvalid_i for the owner.
  - m_rready_o = rsp_ready_i[o] when an owner exists, else 1 (flush).
  - rsp_data_o, rsp_resp_o and rsp_last_o are passed through combinationally.
  - A nonzero rresp is forwarded unchanged; the arbiter does not act on it.
- Error rule: an R beat handshaked with rlast while outstanding==0, or any m_rvalid_i in IDLE, sets arb_err_o sticky. The beat is consumed (rready=1) and dropped; the counter stays at 0.
- Non-owners see req_ready_o=0 and rsp_valid_o=0 at all times.
- Lock semantics: while req_lock_i[o]=1, ownership is kept even with no valid request, which starves the other requesters. This is intended for atomic table/pointer walks.

Test Plan:
- Single requester: req1 valid, addr 0x1000, len 0 → grant_o=3'b010 next cycle; arvalid asserted with addr 0x1000; after an rlast beat, outstanding returns 0 and the arbiter returns to IDLE.
- Round-robin: req0, req1 and req2 all valid, unlocked, one AR each → grants in the order 0,1,2, then 0 again; rr_ptr wraps to 0.
- Lock: req2 locked, issues 4 ARs with gaps where valid=0 while req0 is valid → grant stays 3'b100 until lock drops; req0 is granted only after drain.
- Outstanding cap: OUTS_MAX=4, arready=1, rvalid held low → exactly 4 ARs accepted, arvalid then 0; one rlast beat allows the 5th AR; a simultaneous AR and rlast keeps the count unchanged.
- Drain: owner drops valid and lock with 2 outstanding → state DRAIN; no AR issued; both R beats go to the old owner; IDLE after the second rlast.
- Error/reset: rvalid+rlast injected in IDLE → arb_err_o=1, rready=1; assert rst_ni low mid-OWNED → all outputs at reset values, arb_err_o cleared.

Source files
------------

// File: rtl/hawk_axi_rd_arb.sv
// hawk_axi_rd_arb: round-robin, session-lockable arbiter sharing one AXI4 read master
module hawk_axi_rd_arb #(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 512,
    parameter int OUTS_MAX = 4,
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int OW = $clog2(OUTS_MAX + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ-1:0]        req_lock_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*8-1:0]      req_len_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_data_o,
    output logic [1:0]                rsp_resp_o,
    output logic                      rsp_last_o,
    input  logic [NUM_REQ-1:0]        rsp_ready_i,
    output logic                      m_arvalid_o,
    output logic [ADDR_W-1:0]         m_araddr_o,
    output logic [7:0]                m_arlen_o,
    input  logic                      m_arready_i,
    input  logic                      m_rvalid_i,
    input  logic [DATA_W-1:0]         m_rdata_i,
    input  logic [1:0]                m_rresp_i,
    input  logic                      m_rlast_i,
    output logic                      m_rready_o,
    output logic [OW-1:0]             outstanding_o,
    output logic                      arb_err_o
);
    typedef enum logic [1:0] {IDLE, OWNED, DRAIN} state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]      own_q, own_d, rr_ptr_q, rr_ptr_d, cand, win;
    logic [OW-1:0]      outs_q, outs_d;
    logic               err_q, err_d, win_found, has_own, ar_hs, r_dec;

    assign has_own       = state_q != IDLE;
    assign grant_o       = grant_q;
    assign outstanding_o = outs_q;
    assign arb_err_o     = err_q;
    assign rsp_data_o    = m_rdata_i;
    assign rsp_resp_o    = m_rresp_i;
    assign rsp_last_o    = m_rlast_i;

    always_comb begin
        m_arvalid_o = state_q == OWNED && req_valid_i[own_q] && outs_q < OW'(OUTS_MAX);
        m_araddr_o  = has_own ? req_addr_i[own_q*ADDR_W +: ADDR_W] : '0;
        m_arlen_o   = has_own ? req_len_i[own_q*8 +: 8] : '0;
        m_rready_o  = has_own ? rsp_ready_i[own_q] : 1'b1;
        req_ready_o = '0;
        rsp_valid_o = '0;
        req_ready_o[own_q] = m_arvalid_o && m_arready_i;
        rsp_valid_o[own_q] = has_own && m_rvalid_i;
    end

    // stray last beats (nothing outstanding) are swallowed without touching the counter
    assign ar_hs  = m_arvalid_o && m_arready_i;
    assign r_dec  = m_rvalid_i && m_rready_o && m_rlast_i && outs_q != '0;
    assign outs_d = outs_q + OW'(ar_hs) - OW'(r_dec);
    assign err_d  = err_q | (m_rvalid_i && !has_own)
                  | (m_rvalid_i && m_rready_o && m_rlast_i && outs_q == '0);

    always_comb begin
        win_found = 1'b0;
        win       = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PW'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!win_found && req_valid_i[cand]) begin
                win_found = 1'b1;
                win       = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        own_d    = own_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: if (win_found) begin
                state_d  = OWNED;
                own_d    = win;
                grant_d  = NUM_REQ'(1) << win;
                rr_ptr_d = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            end
            OWNED: if (!req_valid_i[own_q] && !req_lock_i[own_q]) begin
                state_d = (outs_d != '0) ? DRAIN : IDLE;
                grant_d = (outs_d != '0) ? grant_q : '0;
            end
            DRAIN: if (outs_d == '0) begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            own_q    <= '0;
            rr_ptr_q <= '0;
            outs_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            own_q    <= own_d;
            rr_ptr_q <= rr_ptr_d;
            outs_q   <= outs_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_hawk_axi_rd_arb.sv
// tb_hawk_axi_rd_arb: directed scenarios plus random traffic against a cycle reference model
module tb_hawk_axi_rd_arb;
    localparam int N = 3, AW = 64, DW = 512, OM = 4, OW = 3;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0] valid, lock, rsp_ready, req_ready, grant, rsp_valid;
    logic [N*AW-1:0] addr;
    logic [N*8-1:0] len;
    logic [DW-1:0] rsp_data, rdata;
    logic [1:0] rsp_resp, rresp;
    logic rsp_last, arvalid, arready, rvalid, rlast, rready, err;
    logic [AW-1:0] araddr;
    logic [7:0] arlen;
    logic [OW-1:0] outs;
    int n_chk = 0, n_pass = 0;
    int m_own, m_rr, m_outs;
    bit m_drain, m_err;

    always #5 clk = ~clk;

    hawk_axi_rd_arb #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .OUTS_MAX(OM)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_lock_i(lock),
        .req_addr_i(addr), .req_len_i(len), .req_ready_o(req_ready), .grant_o(grant),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_resp_o(rsp_resp),
        .rsp_last_o(rsp_last), .rsp_ready_i(rsp_ready), .m_arvalid_o(arvalid),
        .m_araddr_o(araddr), .m_arlen_o(arlen), .m_arready_i(arready), .m_rvalid_i(rvalid),
        .m_rdata_i(rdata), .m_rresp_i(rresp), .m_rlast_i(rlast), .m_rready_o(rready),
        .outstanding_o(outs), .arb_err_o(err)
    );

    // one clock: compare every output with the model, then advance the model
    task automatic cycle();
        logic e_arv, e_rr;
        logic [N-1:0] e_gnt, e_rv, e_rq;
        logic [AW-1:0] e_addr;
        logic [7:0] e_len;
        bit ar, rl;
        @(negedge clk);
        #1;
        if (!rst_n) begin
            m_own = -1; m_drain = 0; m_rr = 0; m_outs = 0; m_err = 0;
        end
        e_gnt = '0;
        e_addr = '0;
        e_len = '0;
        e_rr = 1'b1;
        e_arv = 1'b0;
        if (m_own >= 0) begin
            e_gnt[m_own] = 1'b1;
            e_addr = addr[m_own*AW +: AW];
            e_len = len[m_own*8 +: 8];
            e_rr = rsp_ready[m_own];
            e_arv = !m_drain && valid[m_own] && m_outs < OM;
        end
        e_rv = rvalid ? e_gnt : '0;
        e_rq = (e_arv && arready) ? e_gnt : '0;
        n_chk++; if (grant !== e_gnt) $display("FAIL grant got=%b exp=%b", grant, e_gnt); else n_pass++;
        n_chk++; if (outs !== OW'(m_outs)) $display("FAIL outstanding got=%0d exp=%0d", outs, m_outs); else n_pass++;
        n_chk++; if (err !== m_err) $display("FAIL arb_err got=%b exp=%b", err, m_err); else n_pass++;
        n_chk++; if (arvalid !== e_arv) $display("FAIL arvalid got=%b exp=%b", arvalid, e_arv); else n_pass++;
        n_chk++; if (araddr !== e_addr) $display("FAIL araddr got=%h exp=%h", araddr, e_addr); else n_pass++;
        n_chk++; if (arlen !== e_len) $display("FAIL arlen got=%h exp=%h", arlen, e_len); else n_pass++;
        n_chk++; if (req_ready !== e_rq) $display("FAIL req_ready got=%b exp=%b", req_ready, e_rq); else n_pass++;
        n_chk++; if (rsp_valid !== e_rv) $display("FAIL rsp_valid got=%b exp=%b", rsp_valid, e_rv); else n_pass++;
        n_chk++; if (rready !== e_rr) $display("FAIL rready got=%b exp=%b", rready, e_rr); else n_pass++;
        n_chk++; if (rsp_data !== rdata) $display("FAIL rsp_data got=%h exp=%h", rsp_data[63:0], rdata[63:0]); else n_pass++;
        n_chk++; if (rsp_resp !== rresp) $display("FAIL rsp_resp got=%b exp=%b", rsp_resp, rresp); else n_pass++;
        n_chk++; if (rsp_last !== rlast) $display("FAIL rsp_last got=%b exp=%b", rsp_last, rlast); else n_pass++;
        if (rst_n) begin
            ar = e_arv && arready;
            rl = rvalid && e_rr && rlast && m_outs > 0;
            if ((m_own < 0 && rvalid) || (rvalid && e_rr && rlast && m_outs == 0)) m_err = 1;
            m_outs = m_outs + int'(ar) - int'(rl);
            if (m_own < 0) begin
                for (int i = 0; i < N; i++)
                    if (valid[(m_rr + i) % N]) begin
                        m_own = (m_rr + i) % N;
                        m_rr = (m_own + 1) % N;
                        break;
                    end
            end else if (!m_drain) begin
                if (!valid[m_own] && !lock[m_own]) begin
                    if (m_outs != 0) m_drain = 1;
                    else m_own = -1;
                end
            end else if (m_outs == 0) begin
                m_drain = 0;
                m_own = -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid = '0; lock = '0; rsp_ready = '1; arready = 1'b1;
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        valid = '0; lock = '0; rsp_ready = '1; arready = 1'b1;
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
        addr = '0; len = '0;
        #1;
        n_chk++; if (grant !== 3'b000) $display("FAIL reset_grant got=%b exp=000", grant); else n_pass++;
        n_chk++; if (outs !== 3'd0) $display("FAIL reset_outs got=%0d exp=0", outs); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else n_pass++;
        n_chk++; if (rready !== 1'b1) $display("FAIL reset_rready got=%b exp=1", rready); else n_pass++;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        addr[AW +: AW] = 64'h1000;
        len[8 +: 8] = 8'h00;
        valid = 3'b010;
        cycle();
        n_chk++; if (grant !== 3'b010) $display("FAIL single_grant got=%b exp=010", grant); else n_pass++;
        n_chk++; if (arvalid !== 1'b1 || araddr !== 64'h1000) $display("FAIL single_ar got=%b/%h exp=1/1000", arvalid, araddr); else n_pass++;
        cycle();
        valid = '0;
        cycle();
        rvalid = 1'b1; rlast = 1'b1;
        cycle();
        rvalid = 1'b0; rlast = 1'b0;
        n_chk++; if (outs !== 3'd0 || grant !== 3'b000) $display("FAIL single_done got=%0d/%b exp=0/000", outs, grant); else n_pass++;
    endtask

    task automatic test_round_robin();
        do_reset();
        valid = '1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_chk++; if (grant !== 3'(1 << (k % 3))) $display("FAIL rr_grant got=%b exp=%b", grant, 3'(1 << (k % 3))); else n_pass++;
            cycle();
            valid[k % 3] = 1'b0;
            cycle();
            rvalid = 1'b1; rlast = 1'b1;
            cycle();
            rvalid = 1'b0; rlast = 1'b0; valid = '1;
        end
        valid = '0;
        cycle();
    endtask

    task automatic test_lock();
        do_reset();
        valid = 3'b100;
        cycle();
        lock = 3'b100;
        for (int i = 0; i < 8; i++) begin
            valid = {i % 2 == 0, 1'b0, 1'b1};
            cycle();
            n_chk++; if (grant !== 3'b100) $display("FAIL lock_grant got=%b exp=100", grant); else n_pass++;
        end
        n_chk++; if (outs !== 3'd4) $display("FAIL lock_outs got=%0d exp=4", outs); else n_pass++;
        lock = '0; valid = 3'b001;
        cycle();
        rvalid = 1'b1; rlast = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_chk++; if (rsp_valid !== 3'b100) $display("FAIL lock_route got=%b exp=100", rsp_valid); else n_pass++;
            cycle();
        end
        rvalid = 1'b0; rlast = 1'b0;
        cycle();
        n_chk++; if (grant !== 3'b001) $display("FAIL lock_next got=%b exp=001", grant); else n_pass++;
        valid = '0;
        cycle();
        rvalid = 1'b1; rlast = 1'b1;
        cycle();
        rvalid = 1'b0; rlast = 1'b0;
        cycle();
    endtask

    task automatic test_outstanding_cap();
        do_reset();
        valid = 3'b001;
        for (int i = 0; i < 6; i++) cycle();
        n_chk++; if (arvalid !== 1'b0 || outs !== 3'd4) $display("FAIL cap_full got=%b/%0d exp=0/4", arvalid, outs); else n_pass++;
        rvalid = 1'b1; rlast = 1'b1;
        cycle();
        n_chk++; if (arvalid !== 1'b1 || outs !== 3'd3) $display("FAIL cap_reopen got=%b/%0d exp=1/3", arvalid, outs); else n_pass++;
        cycle();
        n_chk++; if (outs !== 3'd3) $display("FAIL cap_same got=%0d exp=3", outs); else n_pass++;
        valid = '0;
        for (int i = 0; i < 4; i++) cycle();
        rvalid = 1'b0; rlast = 1'b0;
        cycle();
    endtask

    task automatic test_drain();
        do_reset();
        valid = 3'b010;
        cycle(); cycle(); cycle();
        valid = '0;
        cycle();
        valid = 3'b010;
        #1;
        n_chk++; if (arvalid !== 1'b0 || grant !== 3'b010) $display("FAIL drain_hold got=%b/%b exp=0/010", arvalid, grant); else n_pass++;
        cycle();
        valid = '0; rvalid = 1'b1; rlast = 1'b1;
        #1;
        n_chk++; if (rsp_valid !== 3'b010) $display("FAIL drain_route got=%b exp=010", rsp_valid); else n_pass++;
        cycle(); cycle();
        rvalid = 1'b0; rlast = 1'b0;
        n_chk++; if (grant !== 3'b000 || outs !== 3'd0) $display("FAIL drain_idle got=%b/%0d exp=000/0", grant, outs); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N * 2; i++) addr[i*32 +: 32] = $urandom;
            for (int i = 0; i < DW / 32; i++) rdata[i*32 +: 32] = $urandom;
            len = N*8'($urandom);
            valid = N'($urandom);
            lock = N'($urandom_range(0, 7) == 0 ? $urandom : 0);
            rsp_ready = N'($urandom | $urandom);
            arready = 1'($urandom);
            rvalid = $urandom_range(0, 2) == 0;
            rlast = 1'($urandom);
            rresp = 2'($urandom);
            cycle();
        end
    endtask

    task automatic test_err_reset();
        do_reset();
        rvalid = 1'b1; rlast = 1'b1;
        #1;
        n_chk++; if (rready !== 1'b1) $display("FAIL err_rready got=%b exp=1", rready); else n_pass++;
        cycle();
        n_chk++; if (err !== 1'b1) $display("FAIL err_set got=%b exp=1", err); else n_pass++;
        rvalid = 1'b0; rlast = 1'b0; valid = 3'b001;
        cycle(); cycle();
        rst_n = 1'b0;
        #1;
        n_chk++; if (grant !== 3'b000 || outs !== 3'd0 || err !== 1'b0) $display("FAIL rst_regs got=%b/%0d/%b exp=000/0/0", grant, outs, err); else n_pass++;
        n_chk++; if (arvalid !== 1'b0 || rready !== 1'b1 || req_ready !== 3'b000) $display("FAIL rst_comb got=%b/%b/%b exp=0/1/000", arvalid, rready, req_ready); else n_pass++;
        cycle();
        rst_n = 1'b1;
        valid = '0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_outstanding_cap();
        test_drain();
        test_random();
        test_err_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
